// File: rtl/mag_peak_detect.sv
// Magnitude event detector: opens an event at thr_hi, tracks the peak and the length, closes at thr_lo.
// Each closed event emits a one-cycle record. Defining MAG_PEAK_POS_EN adds the peak offset output source_pos.
module mag_peak_detect #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LENW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sink_valid,
    input  logic [WIDTH-1:0] sink,
    input  logic [WIDTH-1:0] thr_hi,
    input  logic [WIDTH-1:0] thr_lo,
    output logic             source_valid,
    output logic [WIDTH-1:0] source_peak,
    output logic [LENW-1:0]  source_len,
    output logic             source_trunc,
`ifdef MAG_PEAK_POS_EN
    output logic [LENW-1:0]  source_pos,
`endif
    output logic             busy
);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_ACTIVE = 1'b1;
    localparam logic [LENW-1:0] LEN_ONE   = {{(LENW-1){1'b0}}, 1'b1};
    localparam logic [LENW-1:0] LEN_MAX   = {LENW{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  len_inc;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_peak_q, out_peak_d;
    logic [LENW-1:0]  out_len_q, out_len_d;
    logic             out_trunc_q, out_trunc_d;

`ifdef MAG_PEAK_POS_EN
    logic [LENW-1:0]  pos_q, pos_d;
    logic [LENW-1:0]  out_pos_q, out_pos_d;
`endif

    assign len_inc = len_q + LEN_ONE;

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        len_d       = len_q;
        out_valid_d = 1'b0;
        out_peak_d  = out_peak_q;
        out_len_d   = out_len_q;
        out_trunc_d = out_trunc_q;
`ifdef MAG_PEAK_POS_EN
        pos_d       = pos_q;
        out_pos_d   = out_pos_q;
`endif
        if (sink_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (sink >= thr_hi) begin
                        peak_d  = sink;
                        len_d   = LEN_ONE;
                        state_d = ST_ACTIVE;
`ifdef MAG_PEAK_POS_EN
                        pos_d   = '0;
`endif
                        // A one-sample length limit truncates on the opening sample itself.
                        if (LEN_MAX == LEN_ONE) begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b1;
                            out_peak_d  = sink;
                            out_len_d   = LEN_ONE;
                            out_trunc_d = 1'b1;
`ifdef MAG_PEAK_POS_EN
                            out_pos_d   = '0;
`endif
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (sink < thr_lo) begin
                        // The terminating sample is excluded from the record.
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        out_peak_d  = peak_q;
                        out_len_d   = len_q;
                        out_trunc_d = 1'b0;
`ifdef MAG_PEAK_POS_EN
                        out_pos_d   = pos_q;
`endif
                    end else begin
                        len_d = len_inc;
                        if (sink > peak_q) begin
                            peak_d = sink;
`ifdef MAG_PEAK_POS_EN
                            pos_d  = len_q;
`endif
                        end
                        if (len_inc == LEN_MAX) begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b1;
                            out_peak_d  = peak_d;
                            out_len_d   = len_inc;
                            out_trunc_d = 1'b1;
`ifdef MAG_PEAK_POS_EN
                            out_pos_d   = pos_d;
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            peak_q      <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_peak_q  <= '0;
            out_len_q   <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_peak_q  <= out_peak_d;
            out_len_q   <= out_len_d;
            out_trunc_q <= out_trunc_d;
        end
    end

`ifdef MAG_PEAK_POS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q     <= '0;
            out_pos_q <= '0;
        end else begin
            pos_q     <= pos_d;
            out_pos_q <= out_pos_d;
        end
    end

    assign source_pos = out_pos_q;
`endif

    assign source_valid = out_valid_q;
    assign source_peak  = out_peak_q;
    assign source_len   = out_len_q;
    assign source_trunc = out_trunc_q;
    assign busy         = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_mag_peak_detect.sv
// Directed self-checking bench for mag_peak_detect (WIDTH=8, LENW=4, so events truncate at 15 samples).
module tb_mag_peak_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic       sink_valid;
    logic [7:0] sink, thr_hi, thr_lo;
    logic       source_valid;
    logic [7:0] source_peak;
    logic [3:0] source_len;
    logic       source_trunc;
    logic       busy;
`ifdef MAG_PEAK_POS_EN
    logic [3:0] source_pos;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_rec = 0;
    int rec0;

    mag_peak_detect #(.WIDTH(8), .LENW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sink_valid   (sink_valid),
        .sink         (sink),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .source_valid (source_valid),
        .source_peak  (source_peak),
        .source_len   (source_len),
        .source_trunc (source_trunc),
`ifdef MAG_PEAK_POS_EN
        .source_pos   (source_pos),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (source_valid) n_rec <= n_rec + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample for the next rising edge, return at the following falling edge.
    task automatic send(input logic v, input logic [7:0] d);
        sink_valid = v;
        sink       = d;
        @(negedge clk);
    endtask

    logic [7:0] basic [6];

    initial begin
        basic = '{8'd50, 8'd100, 8'd120, 8'd90, 8'd80, 8'd79};
        rst = 1'b1; sink_valid = 1'b0; sink = '0; thr_hi = 8'd100; thr_lo = 8'd80;
        @(negedge clk); @(negedge clk);
        check_eq("rst_valid", source_valid, 0);
        check_eq("rst_peak", source_peak, 0);
        check_eq("rst_len", source_len, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic event with cycle-exact timing
        send(1, 8'd50);  check_eq("basic_idle_busy", busy, 0);
        send(1, 8'd100); check_eq("basic_open_busy", busy, 1);
        send(1, 8'd120); send(1, 8'd90); send(1, 8'd80);
        check_eq("basic_no_early", source_valid, 0);
        send(1, 8'd79);
        check_eq("basic_valid", source_valid, 1);
        check_eq("basic_peak", source_peak, 120);
        check_eq("basic_len", source_len, 4);
        check_eq("basic_trunc", source_trunc, 0);
        check_eq("basic_busy_low", busy, 0);
`ifdef MAG_PEAK_POS_EN
        check_eq("basic_pos", source_pos, 1);
`endif
        send(0, 8'd0);
        check_eq("basic_pulse_width", source_valid, 0);
        check_eq("basic_peak_hold", source_peak, 120);

        // Same samples with idle gaps carrying junk data
        rec0 = n_rec;
        for (int i = 0; i < 6; i++) begin
            send(1, basic[i]);
            for (int g = 0; g < i % 4; g++) send(0, 8'd255);
        end
        send(0, 8'd0); send(0, 8'd0);
        check_eq("gap_count", n_rec - rec0, 1);
        check_eq("gap_peak", source_peak, 120);
        check_eq("gap_len", source_len, 4);
        check_eq("gap_trunc", source_trunc, 0);

        // Below thr_hi never opens
        rec0 = n_rec;
        send(1, 8'd99); send(1, 8'd99); send(1, 8'd80); send(0, 8'd0);
        check_eq("noev_count", n_rec - rec0, 0);
        check_eq("noev_busy", busy, 0);

        // Equality opens, single-sample event
        send(1, 8'd100); send(1, 8'd79);
        check_eq("edge_valid", source_valid, 1);
        check_eq("edge_peak", source_peak, 100);
        check_eq("edge_len", source_len, 1);

        // Tied maximum keeps the first occurrence
        send(1, 8'd100); send(1, 8'd120); send(1, 8'd120); send(1, 8'd90); send(1, 8'd50);
        check_eq("tie_valid", source_valid, 1);
        check_eq("tie_peak", source_peak, 120);
        check_eq("tie_len", source_len, 4);
`ifdef MAG_PEAK_POS_EN
        check_eq("tie_pos", source_pos, 1);
`endif

        // Length limit at 15 samples
        for (int i = 0; i < 15; i++) send(1, 8'd200);
        check_eq("trunc_valid", source_valid, 1);
        check_eq("trunc_len", source_len, 15);
        check_eq("trunc_flag", source_trunc, 1);
        check_eq("trunc_peak", source_peak, 200);
        check_eq("trunc_busy_low", busy, 0);
        send(1, 8'd200); check_eq("trunc_reopen_busy", busy, 1);
        send(1, 8'd200); check_eq("trunc_second_busy", busy, 1);
        send(1, 8'd50);
        check_eq("trunc_next_len", source_len, 2);
        check_eq("trunc_next_flag", source_trunc, 0);

        // Reset in the middle of an event
        send(1, 8'd150); check_eq("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_peak", source_peak, 0);
        check_eq("mid_rst_len", source_len, 0);
        @(negedge clk);
        rst = 1'b0;
        rec0 = n_rec;
        send(1, 8'd79);
        send(0, 8'd0);
        check_eq("post_rst_quiet", source_valid, 0);
        send(1, 8'd101); send(1, 8'd50);
        check_eq("post_rst_valid", source_valid, 1);
        check_eq("post_rst_peak", source_peak, 101);
        check_eq("post_rst_len", source_len, 1);
        send(0, 8'd0);
        check_eq("post_rst_count", n_rec - rec0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mag_peak_detect.md
# mag_peak_detect

Event detector placed directly downstream of the vector-magnitude stage. It consumes the unsigned magnitude stream, opens an event when magnitude reaches an upper threshold, tracks the peak and duration, and closes the event with hysteresis at a lower threshold. Each closed event produces a one-cycle summary record for the capture/readout logic.

## Interface
- WIDTH, 16, magnitude width; sink, thresholds and source_peak are UQ<WIDTH>.0
- LENW, 8, event length counter width; maximum event length is 2^LENW−1 samples
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- sink_valid  in  1  sink carries a valid magnitude this cycle
- sink  in  WIDTH  magnitude sample, UQ<WIDTH>.0
- thr_hi  in  WIDTH  open threshold, UQ<WIDTH>.0
- thr_lo  in  WIDTH  close threshold, UQ<WIDTH>.0
- source_valid  out  1  one-cycle pulse: event record valid
- source_peak  out  WIDTH  maximum magnitude within the event
- source_len  out  LENW  number of samples in the event
- source_trunc  out  1  event closed by length limit, not by thr_lo
- busy  out  1  high while in state ACTIVE

## Operation
- States: IDLE, ACTIVE. Only cycles with sink_valid=1 are processed; with sink_valid=0 no state, counter or peak changes.
- IDLE: sink ≥ thr_hi → ACTIVE, peak←sink, len←1, pos←0. Otherwise stay.
- ACTIVE, sink < thr_lo → close event (trunc=0) with current peak/len; terminating sample is not included; → IDLE. The terminating sample is not re-evaluated against thr_hi.
- ACTIVE, sink ≥ thr_lo → len←len+1; if sink > peak then peak←sink, pos←len (strict compare: first occurrence of a tied maximum wins).
- Length limit: when an included sample brings len to 2^LENW−1, the event closes on that same sample with trunc=1 → IDLE; the next valid sample is evaluated as IDLE.
- Comparisons unsigned. Equality: sink=thr_hi opens; sink=thr_lo keeps the event open.
- Thresholds are sampled on every processed cycle; changing them mid-event takes effect on the next valid sample. thr_lo > thr_hi is legal and yields no hysteresis; rules above still apply literally.
- Reset: state IDLE; all outputs and internal registers 0. Reset mid-event discards the event; no record is emitted.

## Timing
- All outputs registered. source_valid asserts exactly one cycle after the clock edge at which the closing sample is processed, for one cycle.
- source_peak, source_len, source_trunc (and source_pos) update together with source_valid and hold until the next record.
- busy goes high the cycle after the opening sample, low the cycle after the closing sample.
- Full throughput: a sample every cycle; back-to-back events possible (close on sample n, open on sample n+1).
- Reset asserted: outputs 0 immediately (asynchronous); operation resumes on the first edge after deassertion.

## Configuration
- MAG_PEAK_POS_EN defined: adds output source_pos [LENW-1:0], the 0-based offset of the peak sample within the event, updated with the record.
- Not defined: port and pos register absent; all other behaviour identical.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 at once, busy=0, no source_valid after release until a new event closes.
- Basic event (WIDTH=8, LENW=4, thr_hi=100, thr_lo=80): samples 50,100,120,90,80,79 every cycle → one pulse a cycle after 79: peak=120, len=4, trunc=0, pos=1.
- Gapped valid: same samples with 0–3 idle cycles (sink_valid=0, sink=255) between each → identical record; idle data ignored.
- Threshold edges: 99,99,80 → no event; 100,79 → peak=100, len=1; ties 120,120 inside event → pos of first 120.
- Truncation: 17 consecutive samples of 200 → record after 15th: len=15, trunc=1, peak=200; 16th opens new event (busy re-asserts), 17th included.
- Reset mid-event: open with 150, assert rst before close → no record; after release, 79 produces nothing, 101,50 produces peak=101, len=1.
